nand_tt_checker: RTL and testbench
==================================

// Module: nand_tt_checker
// PURPOSE
//  Self-checking stimulus/response stage for the 2-input gate cell (a,b -> c).
//  Sits directly upstream and downstream of the gate: drives the gate's a/b inputs
//  through all four input combinations, samples its c output and compares it
//  against an expected truth table. Reports a per-vector error mask, an error
//  count, a pass flag and a saturating count of completed runs.
// PARAMETERS
//  HOLD_CYCLES  4        cycles each vector is held before sampling c_in; must be >= 1
//  EXPECT       4'b0111  expected c per vector; bit index = {a,b}; default is NAND
//  CNT_W        8        width of run_count
// PORTS
//  clk        in   1      single clock; all state changes on its rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request one full run; sampled only in IDLE
//  c_in       in   1      output c of the gate under test
//  a_out      out  1      drives gate input a (registered)
//  b_out      out  1      drives gate input b (registered)
//  busy       out  1      high in DRIVE and SAMPLE
//  done       out  1      one-cycle pulse in DONE
//  pass       out  1      1 = last completed run had no mismatches; held until next start
//  err_mask   out  4      bit i set = vector {a,b}=i mismatched in the current/last run
//  err_count  out  3      number of mismatching vectors, 0..4
//  run_count  out  CNT_W  number of completed runs; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, idx=0, hold counter=0; a_out, b_out,
//    busy, done, pass, err_mask, err_count and run_count all 0.
//  - All outputs are registered. c_in is sampled only in SAMPLE, never in DRIVE.
//  - FSM states: IDLE, DRIVE, SAMPLE, DONE.
//  - IDLE: a_out=b_out=0.
//    start=1 -> DRIVE, with idx=0, err_mask=0, err_count=0 and pass=0.
//  - DRIVE: {a_out,b_out}=idx, held for exactly HOLD_CYCLES cycles, then -> SAMPLE.
//  - SAMPLE (1 cycle): a_out/b_out unchanged.
//    - If c_in != EXPECT[idx]: set err_mask[idx] and increment err_count.
//    - idx<3 -> idx+1 and go to DRIVE. idx==3 -> DONE.
//  - DONE (1 cycle):
//    - done=1; a_out=b_out=0.
//    - pass <= (final err_mask==0), including the vector-3 result.
//    - run_count += 1, saturating at 2^CNT_W-1.
//    - Then -> IDLE.
//  - Timing: start sampled high at edge of cycle 0 -> DRIVE from cycle 1.
//    - Each vector takes HOLD_CYCLES+1 cycles.
//    - done is high in cycle 1+4*(HOLD_CYCLES+1).
//    - busy is high from cycle 1 through the last SAMPLE.
//  - start is ignored while busy and in DONE; there is no queueing.
//    - start held high continuously: the next run begins on the IDLE cycle after DONE.
//  - err_mask, err_count and pass hold their values after DONE until the next
//    accepted start.
//  - Reset mid-run aborts immediately: no done pulse; run_count is cleared with
//    all other state.
// TESTING
//  1. NAND gate, HOLD=4, start pulse in cycle 0 -> busy in cycles 1..20, done in
//     cycle 21; pass=1, err_mask=0000, err_count=0, run_count=1.
//  2. c_in tied 0 -> err_mask=0111, err_count=3, pass=0; done still in cycle 21.
//  3. AND gate in place of NAND -> err_mask=1111, err_count=4, pass=0.
//  4. start held high for 3 runs -> done pulses in cycles 21, 43 and 65;
//     run_count=3; start has no effect mid-run.
//  5. rst asserted while idx=2 in DRIVE -> all outputs 0 at once and no done;
//     a fresh start then completes with pass=1.
//  6. CNT_W=2, 5 back-to-back runs -> run_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/nand_tt_checker.sv
// nand_tt_checker
// Stimulus/response checker for a 2-input gate cell (a,b -> c). It walks the
// gate inputs through all four combinations, holds each one for HOLD_CYCLES
// cycles, samples the gate output once per vector and compares it against the
// expected truth table EXPECT (bit index = {a,b}). Results are an error mask,
// an error count, a pass flag and a saturating count of completed runs.
module nand_tt_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXPECT      = 4'b0111,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             c_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_mask,
    output logic [2:0]       err_count,
    output logic [CNT_W-1:0] run_count
);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Hold counter runs 0..HOLD_CYCLES-1 while a vector is driven.
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
    localparam logic [1:0]       IDX_LAST = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [1:0]        idx_q,       idx_d;
    logic [HOLD_W-1:0] hold_q,      hold_d;
    logic              a_q,         a_d;
    logic              b_q,         b_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              pass_q,      pass_d;
    logic [3:0]        err_mask_q,  err_mask_d;
    logic [2:0]        err_count_q, err_count_d;
    logic [CNT_W-1:0]  run_count_q, run_count_d;

    // Mismatch of the gate output against the expected value for the vector
    // currently applied; only acted upon in SAMPLE.
    logic              mismatch;

    assign mismatch = (c_in != EXPECT[idx_q]);

    // Next-state and registered-output computation. Outputs are computed for
    // the state being entered so that they appear together with that state.
    always_comb begin
        // NOTE: every signal gets a default here first; a path that leaves one
        // unassigned would infer a latch in this combinational block.
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_mask_d  = err_mask_q;
        err_count_d = err_count_q;
        run_count_d = run_count_q;

        case (state_q)
            S_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    state_d     = S_DRIVE;
                    idx_d       = 2'd0;
                    hold_d      = '0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_mask_d  = 4'b0000;
                    err_count_d = 3'd0;
                end
            end

            S_DRIVE: begin
                // Vector {a,b}=idx is already on the outputs; just time it.
                if (hold_q == HOLD_LAST) begin
                    state_d = S_SAMPLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    err_mask_d[idx_q] = 1'b1;
                    err_count_d       = err_count_q + 3'd1;
                end
                if (idx_q == IDX_LAST) begin
                    // Last vector: the pass flag must see this vector's result,
                    // so it is derived from the updated mask, not the old one.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = (err_mask_d == 4'b0000);
                    if (run_count_q != RUN_MAX) begin
                        run_count_d = run_count_q + 1'b1;
                    end
                end else begin
                    state_d    = S_DRIVE;
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                end
            end

            S_DONE: begin
                // start is deliberately ignored here; a held start is picked
                // up on the following IDLE cycle.
                state_d = S_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    // State register with immediate (asynchronous) reset; a reset mid-run
    // aborts without a done pulse and clears the run counter as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            hold_q      <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_mask_q  <= 4'b0000;
            err_count_q <= 3'd0;
            run_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values computed above, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_mask_q  <= err_mask_d;
            err_count_q <= err_count_d;
            run_count_q <= run_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;
    assign run_count = run_count_q;

endmodule

// File: tb/tb_nand_tt_checker.sv
// tb_nand_tt_checker
// Scoreboard bench: each started run pushes its expected result (mask, count,
// pass, run count and the cycle its done pulse must appear in); monitors pop
// and compare whenever a done pulse is seen. A second instance with CNT_W=2
// exercises run-counter saturation.
module tb_nand_tt_checker;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
        logic [7:0] runs;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic c_in, c_in2;
    int   gate_mode = 0;  // 0 NAND, 1 tied 0, 2 AND

    logic       a_out, b_out, busy, done, pass;
    logic [3:0] err_mask;
    logic [2:0] err_count;
    logic [7:0] run_count;

    logic       a2, b2, busy2, done2, pass2;
    logic [3:0] err_mask2;
    logic [2:0] err_count2;
    logic [1:0] run_count2;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Gate under test models
    always_comb begin
        case (gate_mode)
            1:       c_in = 1'b0;
            2:       c_in = a_out & b_out;
            default: c_in = ~(a_out & b_out);
        endcase
    end
    assign c_in2 = ~(a2 & b2);

    nand_tt_checker #(.HOLD_CYCLES(4), .EXPECT(4'b0111), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .c_in(c_in),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .err_count(err_count), .run_count(run_count)
    );

    nand_tt_checker #(.HOLD_CYCLES(4), .EXPECT(4'b0111), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .c_in(c_in2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_mask(err_mask2), .err_count(err_count2), .run_count(run_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] m, input logic [2:0] c, input logic p,
                        input logic [7:0] r, input int at, input bit second);
        exp_t e;
        e.mask = m; e.cnt = c; e.pass = p; e.runs = r; e.cyc = at;
        if (second) exp2_q.push_back(e);
        else        exp_q.push_back(e);
    endtask

    // Monitor for the main instance
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("err_mask",   32'(err_mask), 32'(e.mask));
                check("err_count",  32'(err_count), 32'(e.cnt));
                check("pass",       32'(pass), 32'(e.pass));
                check("run_count",  32'(run_count), 32'(e.runs));
                check("ab_in_done", 32'({a_out, b_out}), 32'd0);
            end
        end
    end

    // Monitor for the saturating instance
    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_done2", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp2_q.pop_front();
                check("done_cycle2", 32'(cyc), 32'(e.cyc));
                check("pass2",       32'(pass2), 32'(e.pass));
                check("run_count2",  32'(run_count2), 32'(e.runs));
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size() + exp2_q.size()), 32'd0);
            exp_q.delete();
            exp2_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ab"},    32'({a_out, b_out}), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_mask"},  32'(err_mask), 32'd0);
        check({tag, "_cnt"},   32'(err_count), 32'd0);
        check({tag, "_runs"},  32'(run_count), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One single-pulse run on the main instance
    task automatic single_run(input logic [3:0] m, input logic [2:0] c, input logic p,
                              input logic [7:0] r);
        @(negedge clk);
        push(m, c, p, r, cyc + 21, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(40);
    endtask

    initial begin
        int n0;

        do_reset();

        // 1: NAND gate, busy window cycles 1..20, done in cycle 21
        @(negedge clk);
        n0 = cyc;
        push(4'b0000, 3'd0, 1'b1, 8'd1, n0 + 21, 1'b0);
        start = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check($sformatf("busy_c%0d", k), 32'(busy), 32'(k <= 20));
        end
        drain(10);

        // 2: c tied low
        gate_mode = 1;
        single_run(4'b0111, 3'd3, 1'b0, 8'd2);
        // Results hold after DONE
        repeat (3) @(negedge clk);
        check("hold_mask", 32'(err_mask), 32'h7);
        check("hold_cnt",  32'(err_count), 32'd3);

        // 3: AND gate instead of NAND
        gate_mode = 2;
        single_run(4'b1111, 3'd4, 1'b0, 8'd3);

        // 4: start held for three back-to-back runs
        gate_mode = 0;
        do_reset();
        @(negedge clk);
        n0 = cyc;
        push(4'b0000, 3'd0, 1'b1, 8'd1, n0 + 21, 1'b0);
        push(4'b0000, 3'd0, 1'b1, 8'd2, n0 + 43, 1'b0);
        push(4'b0000, 3'd0, 1'b1, 8'd3, n0 + 65, 1'b0);
        start = 1'b1;
        repeat (65) @(negedge clk);
        start = 1'b0;
        drain(10);
        repeat (30) @(negedge clk);
        check("no_extra_run", 32'(busy), 32'd0);

        // 5: reset while vector 2 is being driven
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);   // cycle 12: DRIVE, idx=2
        check("mid_ab",   32'({a_out, b_out}), 32'b10);
        check("mid_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_run", 32'(run_count), 32'd0);
        single_run(4'b0000, 3'd0, 1'b1, 8'd1);

        // 6: CNT_W=2 saturation over five back-to-back runs
        @(negedge clk);
        n0 = cyc;
        push(4'b0000, 3'd0, 1'b1, 8'd1, n0 + 21,  1'b1);
        push(4'b0000, 3'd0, 1'b1, 8'd2, n0 + 43,  1'b1);
        push(4'b0000, 3'd0, 1'b1, 8'd3, n0 + 65,  1'b1);
        push(4'b0000, 3'd0, 1'b1, 8'd3, n0 + 87,  1'b1);
        push(4'b0000, 3'd0, 1'b1, 8'd3, n0 + 109, 1'b1);
        start2 = 1'b1;
        repeat (109) @(negedge clk);
        start2 = 1'b0;
        drain(10);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
